// File: rtl/alu_mac_sequencer.sv
// Dot-product sequencer that drives an external combinational ALU:
// each element pair is multiplied, then accumulated modulo 2^16.
module alu_mac_sequencer #(
  parameter logic [2:0] OP_MUL = 3'd2,
  parameter logic [2:0] OP_ADD = 3'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  length,
  input  logic        op_valid,
  input  logic [15:0] a_data,
  input  logic [15:0] b_data,
  output logic        op_ready,
  output logic [15:0] in1,
  output logic [15:0] in2,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_out,
  output logic        busy,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        result_zero
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_OP = 3'd1,
    MUL     = 3'd2,
    ADD     = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  count_inc_s;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [15:0] prod_q, prod_d, acc_q, acc_d;
  logic [15:0] result_q, result_d;
  logic        result_zero_q, result_zero_d;
  logic        result_valid_q, result_valid_d;
  logic        op_ready_q, op_ready_d;
  logic        busy_q, busy_d;
  logic [15:0] in1_q, in1_d, in2_q, in2_d;
  logic [2:0]  alu_op_q, alu_op_d;

  assign count_inc_s = count_q + 8'd1;

  // Next-state and datapath; outputs are decoded from the next state so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    count_d        = count_q;
    a_d            = a_q;
    b_d            = b_q;
    prod_d         = prod_q;
    acc_d          = acc_q;
    result_d       = result_q;
    result_zero_d  = result_zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = length;
          acc_d   = 16'd0;
          count_d = 8'd0;
          state_d = (length == 8'd0) ? DONE : WAIT_OP;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_OP: begin
        if (op_valid) begin
          a_d     = a_data;
          b_d     = b_data;
          state_d = MUL;
        end else begin
          state_d = WAIT_OP;
        end
      end
      MUL: begin
        prod_d  = alu_out;
        state_d = ADD;
      end
      ADD: begin
        acc_d   = alu_out;
        count_d = count_inc_s;
        state_d = (count_inc_s == len_q) ? DONE : WAIT_OP;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    op_ready_d     = (state_d == WAIT_OP);
    busy_d         = (state_d != IDLE);
    result_valid_d = (state_d == DONE);
    if (state_d == DONE) begin
      result_d      = acc_d;
      result_zero_d = (acc_d == 16'd0);
    end else begin
      result_d      = result_q;
      result_zero_d = result_zero_q;
    end

    case (state_d)
      MUL: begin
        in1_d    = a_d;
        in2_d    = b_d;
        alu_op_d = OP_MUL;
      end
      ADD: begin
        in1_d    = acc_d;
        in2_d    = prod_d;
        alu_op_d = OP_ADD;
      end
      default: begin
        in1_d    = 16'd0;
        in2_d    = 16'd0;
        alu_op_d = OP_ADD;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      len_q          <= 8'd0;
      count_q        <= 8'd0;
      a_q            <= 16'd0;
      b_q            <= 16'd0;
      prod_q         <= 16'd0;
      acc_q          <= 16'd0;
      result_q       <= 16'd0;
      result_zero_q  <= 1'b1;
      result_valid_q <= 1'b0;
      op_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      in1_q          <= 16'd0;
      in2_q          <= 16'd0;
      alu_op_q       <= OP_ADD;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      count_q        <= count_d;
      a_q            <= a_d;
      b_q            <= b_d;
      prod_q         <= prod_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_zero_q  <= result_zero_d;
      result_valid_q <= result_valid_d;
      op_ready_q     <= op_ready_d;
      busy_q         <= busy_d;
      in1_q          <= in1_d;
      in2_q          <= in2_d;
      alu_op_q       <= alu_op_d;
    end
  end

  assign op_ready     = op_ready_q;
  assign busy         = busy_q;
  assign in1          = in1_q;
  assign in2          = in2_q;
  assign alu_op       = alu_op_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign result_zero  = result_zero_q;

endmodule
